rgb_seq_pwm: RTL and testbench

RGB_SEQ_PWM -- requirements
Module: rgb_seq_pwm

---
 rtl/rgb_seq_pwm.sv | 221 ++++++++++++++++++++++
 tb/tb_rgb_seq_pwm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_seq_pwm.sv
// Sequenced multi-channel LED PWM driver: OFF, ROTATE, BREATHE and CROSSFADE
// patterns. Duties update only on PWM period boundaries to avoid glitches.
module rgb_seq_pwm #(
  parameter int CHANNELS    = 3,
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 4_000_000,
  parameter int FADE_CYCLES = 7812,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [CHANNELS-1:0] pwm,
  output logic [CH_W-1:0]     active_ch,
  output logic                step
);

  localparam int SP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int FP_W = (FADE_CYCLES > 1) ? $clog2(FADE_CYCLES) : 1;

  localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_ZERO  = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] LVL_TOP   = MAX - LVL_ONE;
  localparam logic [SP_W-1:0]     STEP_LAST = SP_W'(STEP_CYCLES - 1);
  localparam logic [FP_W-1:0]     FADE_LAST = FP_W'(FADE_CYCLES - 1);
  localparam logic [CH_W-1:0]     CH_LAST   = CH_W'(CHANNELS - 1);
  localparam logic [CH_W-1:0]     CH_ZERO   = {CH_W{1'b0}};

  typedef enum logic [1:0] {
    MODE_OFF = 2'b00,
    MODE_ROT = 2'b01,
    MODE_BRE = 2'b10,
    MODE_XF  = 2'b11
  } mode_e;

  // (x * b) >> PWM_BITS on the full-width product, upper half kept
  function automatic logic [PWM_BITS-1:0] f_scale(input logic [PWM_BITS-1:0] x,
                                                  input logic [PWM_BITS-1:0] b);
    logic [2*PWM_BITS-1:0] p;
    p = {{PWM_BITS{1'b0}}, x} * {{PWM_BITS{1'b0}}, b};
    return p[2*PWM_BITS-1:PWM_BITS];
  endfunction

  mode_e                             w_mode;
  logic                              w_mode_chg;
  logic                              w_step_tick;
  logic                              w_fade_tick;
  logic [CH_W-1:0]                   w_next_ch;
  logic [CH_W-1:0]                   w_active_nx;
  logic [PWM_BITS-1:0]               w_level_nx;
  logic                              w_dir_nx;
  logic                              w_step_nx;
  logic [SP_W-1:0]                   w_step_pre_nx;
  logic [FP_W-1:0]                   w_fade_pre_nx;
  logic [PWM_BITS-1:0]               w_scaled_lvl;
  logic [PWM_BITS-1:0]               w_scaled_inv;
  logic [CHANNELS-1:0][PWM_BITS-1:0] w_duty_nx;
  logic [CHANNELS-1:0]               w_pwm_nx;

  logic [PWM_BITS-1:0]               r_pwm_cnt;
  logic [CHANNELS-1:0][PWM_BITS-1:0] r_duty_q;
  logic [CHANNELS-1:0]               r_pwm;
  logic [CH_W-1:0]                   r_active_ch;
  logic                              r_step;
  logic [PWM_BITS-1:0]               r_level;
  logic                              r_dir;
  logic [SP_W-1:0]                   r_step_pre;
  logic [FP_W-1:0]                   r_fade_pre;
  logic [1:0]                        r_mode_q;

  assign w_mode       = mode_e'(mode);
  assign w_scaled_lvl = f_scale(r_level, brightness);
  assign w_scaled_inv = f_scale(MAX - r_level, brightness);

  // Sequencer next-state: prescalers, lead channel, fade level/direction, step pulse
  always_comb begin
    w_mode_chg    = (mode != r_mode_q);
    w_step_tick   = (r_step_pre == STEP_LAST);
    w_fade_tick   = (r_fade_pre == FADE_LAST);
    w_active_nx   = r_active_ch;
    w_level_nx    = r_level;
    w_dir_nx      = r_dir;
    w_step_nx     = 1'b0;
    if (r_active_ch == CH_LAST) begin
      w_next_ch = CH_ZERO;
    end else begin
      w_next_ch = r_active_ch + CH_W'(1);
    end
    if (w_step_tick) begin
      w_step_pre_nx = {SP_W{1'b0}};
    end else begin
      w_step_pre_nx = r_step_pre + SP_W'(1);
    end
    if (w_fade_tick) begin
      w_fade_pre_nx = {FP_W{1'b0}};
    end else begin
      w_fade_pre_nx = r_fade_pre + FP_W'(1);
    end

    // A mode change outranks any coincident tick
    if (w_mode_chg) begin
      w_active_nx   = CH_ZERO;
      w_level_nx    = LVL_ZERO;
      w_dir_nx      = 1'b0;
      w_step_pre_nx = {SP_W{1'b0}};
      w_fade_pre_nx = {FP_W{1'b0}};
    end else begin
      case (w_mode)
        MODE_ROT: begin
          if (w_step_tick) begin
            w_active_nx = w_next_ch;
            w_step_nx   = 1'b1;
          end else begin
            w_step_nx   = 1'b0;
          end
        end
        MODE_BRE: begin
          w_active_nx = CH_ZERO;
          if (!w_fade_tick) begin
            w_level_nx = r_level;
          end else if (!r_dir) begin
            w_level_nx = r_level + LVL_ONE;
            w_dir_nx   = (r_level == LVL_TOP);
          end else begin
            w_level_nx = r_level - LVL_ONE;
            w_dir_nx   = (r_level != LVL_ONE);
          end
        end
        MODE_XF: begin
          if (!w_fade_tick) begin
            w_level_nx = r_level;
          end else if (r_level == MAX) begin
            w_active_nx = w_next_ch;
            w_level_nx  = LVL_ZERO;
            w_step_nx   = 1'b1;
          end else begin
            w_level_nx  = r_level + LVL_ONE;
          end
        end
        default: begin
          w_active_nx   = CH_ZERO;
          w_level_nx    = LVL_ZERO;
          w_dir_nx      = 1'b0;
          w_step_pre_nx = {SP_W{1'b0}};
          w_fade_pre_nx = {FP_W{1'b0}};
        end
      endcase
    end
  end

  // Per-channel duty targets for the next PWM period and comparator outputs
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_duty_nx[i] = LVL_ZERO;
      w_pwm_nx[i]  = (r_pwm_cnt < r_duty_q[i]);
      case (w_mode)
        MODE_ROT: begin
          if (CH_W'(i) == r_active_ch) begin
            w_duty_nx[i] = brightness;
          end else begin
            w_duty_nx[i] = LVL_ZERO;
          end
        end
        MODE_BRE: w_duty_nx[i] = w_scaled_lvl;
        MODE_XF: begin
          if (CH_W'(i) == r_active_ch) begin
            w_duty_nx[i] = w_scaled_inv;
          end else if (CH_W'(i) == w_next_ch) begin
            w_duty_nx[i] = w_scaled_lvl;
          end else begin
            w_duty_nx[i] = LVL_ZERO;
          end
        end
        default: w_duty_nx[i] = LVL_ZERO;
      endcase
    end
  end

  // PWM counter, period-aligned duty load and registered PWM outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= LVL_ZERO;
      r_duty_q  <= '0;
      r_pwm     <= {CHANNELS{1'b0}};
    end else begin
      r_pwm_cnt <= r_pwm_cnt + LVL_ONE;
      r_pwm     <= w_pwm_nx;
      if (r_pwm_cnt == MAX) begin
        r_duty_q <= w_duty_nx;
      end
    end
  end

  // Sequencer state registers and last-sampled mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_ch <= CH_ZERO;
      r_step      <= 1'b0;
      r_level     <= LVL_ZERO;
      r_dir       <= 1'b0;
      r_step_pre  <= {SP_W{1'b0}};
      r_fade_pre  <= {FP_W{1'b0}};
      r_mode_q    <= 2'b00;
    end else begin
      r_active_ch <= w_active_nx;
      r_step      <= w_step_nx;
      r_level     <= w_level_nx;
      r_dir       <= w_dir_nx;
      r_step_pre  <= w_step_pre_nx;
      r_fade_pre  <= w_fade_pre_nx;
      r_mode_q    <= mode;
    end
  end

  assign pwm       = r_pwm;
  assign active_ch = r_active_ch;
  assign step      = r_step;

endmodule

// File: tb/tb_rgb_seq_pwm.sv
// Directed bench for rgb_seq_pwm: two instances (fade prescale 1 and 2) share
// stimulus; k counts rising edges since the latest reset release.
module tb_rgb_seq_pwm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [3:0] brightness;
  logic [2:0] pwm_a, pwm_b;
  logic [1:0] ach_a, ach_b;
  logic       step_a, step_b;

  int n_cmp = 0;
  int n_err = 0;
  int k     = 0;

  always #5 clk = ~clk;

  rgb_seq_pwm #(.CHANNELS(3), .PWM_BITS(4), .STEP_CYCLES(20), .FADE_CYCLES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .brightness(brightness),
    .pwm(pwm_a), .active_ch(ach_a), .step(step_a));

  rgb_seq_pwm #(.CHANNELS(3), .PWM_BITS(4), .STEP_CYCLES(20), .FADE_CYCLES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .brightness(brightness),
    .pwm(pwm_b), .active_ch(ach_b), .step(step_b));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  task automatic run_to(input int t);
    while (k < t) tick();
  endtask

  initial begin
    int first_hi, c0, c1, c2, cz, nst, n111, npart, lv_bad, d, lv_exp;
    int spos[3];
    int sach[3];

    // Reset state
    rst_n = 1'b0; mode = 2'b01; brightness = 4'd8;
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_a), 0);
    chk("rst_ach", int'(ach_a), 0);
    chk("rst_step", int'(step_a), 0);

    // ROTATE cold start, brightness 8
    rst_n = 1'b1; k = 0;
    first_hi = 0; c0 = 0; c1 = 0; cz = 0; nst = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (first_hi == 0 && pwm_a != 3'b000) first_hi = k;
      if (k >= 17 && k <= 32 && pwm_a[0]) c0++;
      if (k >= 33 && k <= 48 && pwm_a[1]) c1++;
      if (k <= 32 && pwm_a[2:1] != 2'b00) cz++;
      if (step_a) begin
        if (nst < 3) begin
          spos[nst] = k;
          sach[nst] = int'(ach_a);
        end
        nst++;
      end
    end
    chk("rot_first_high", first_hi, 17);
    chk("rot_ch0_duty", c0, 8);
    chk("rot_ch1_duty", c1, 8);
    chk("rot_others_low", cz, 0);
    chk("rot_step_count", nst, 3);
    chk("rot_step0_pos", spos[0], 21);
    chk("rot_step1_pos", spos[1], 41);
    chk("rot_step2_pos", spos[2], 61);
    chk("rot_ach_after0", sach[0], 1);
    chk("rot_ach_after1", sach[1], 2);
    chk("rot_ach_after2", sach[2], 0);

    // brightness 0 -> constant low from the wrap at edge 80
    brightness = 4'd0;
    cz = 0;
    while (k < 95) begin
      tick();
      if (k >= 81 && pwm_a != 3'b000) cz++;
    end
    chk("bri0_all_low", cz, 0);

    // brightness 15 -> low exactly once per 16 cycles, ch1 lit
    brightness = 4'd15;
    cz = 0;
    while (k < 112) begin
      tick();
      if (k == 100) chk("bri15_ch1_lit", int'(pwm_a), 2);
      if (k >= 97 && pwm_a == 3'b000) cz++;
    end
    chk("bri15_low_cycles", cz, 1);

    // ROTATE -> BREATHE on the step_tick edge 161
    run_to(160);
    chk("pre_chg_ach", int'(ach_a), 1);
    mode = 2'b10;
    nst = 0; n111 = 0; npart = 0; lv_bad = 0;
    while (k < 192) begin
      tick();
      if (k == 161) chk("chg_ach_cleared", int'(ach_a), 0);
      if (k == 170) chk("chg_old_duty_kept", int'(pwm_a), 2);
      if (k == 176) chk("chg_wrap_low", int'(pwm_a), 0);
      if (k == 177) chk("chg_new_duty", int'(pwm_a), 7);
      if (step_a) nst++;
      if (k >= 177 && pwm_a == 3'b111) n111++;
      if (k >= 177 && pwm_a != 3'b111 && pwm_a != 3'b000) npart++;
      d = k - 161;
      lv_exp = (d <= 15) ? d : ((d <= 30) ? 30 - d : d - 30);
      if (int'(u_dut_a.r_level) != lv_exp) lv_bad++;
    end
    chk("chg_no_step", nst, 0);
    chk("bre_equal_duty", n111, 13);
    chk("bre_channels_equal", npart, 0);
    chk("bre_level_triangle", lv_bad, 0);
    chk("bre_ach_zero", int'(ach_a), 0);

    // CROSSFADE on instance b (fade every 2 cycles), brightness 15
    run_to(200);
    mode = 2'b11;
    c0 = 0; c1 = 0; c2 = 0; cz = 0; nst = 0; first_hi = 0;
    while (k < 244) begin
      tick();
      if (k >= 209 && k <= 224 && pwm_b[0]) c0++;
      if (k >= 209 && k <= 224 && pwm_b[1]) c1++;
      if (k >= 225 && k <= 240 && pwm_b[0]) c2++;
      if (k >= 225 && k <= 240 && pwm_b[1]) cz++;
      if (k == 232) chk("xf_ach_before", int'(ach_b), 0);
      if (k == 233) chk("xf_ach_after", int'(ach_b), 1);
      if (step_b) begin
        nst++;
        first_hi = k;
      end
    end
    chk("xf_ch0_early", c0, 11);
    chk("xf_ch1_early", c1, 2);
    chk("xf_ch0_late", c2, 3);
    chk("xf_ch1_late", cz, 10);
    chk("xf_step_count", nst, 1);
    chk("xf_step_pos", first_hi, 233);

    // Asynchronous reset mid-crossfade
    run_to(245);
    chk("xf_pre_rst_pwm", int'(pwm_b), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm", int'(pwm_b), 0);
    chk("arst_ach", int'(ach_b), 0);
    chk("arst_step", int'(step_b), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; k = 0;

    // Restart must match a crossfade cold start
    cz = 0; nst = 0; first_hi = 0;
    while (k < 40) begin
      tick();
      if (k <= 16 && pwm_b != 3'b000) cz++;
      if (k == 17) chk("cold_pwm_k17", int'(pwm_b), 3);
      if (k == 23) chk("cold_pwm_k23", int'(pwm_b), 1);
      if (k == 24) chk("cold_pwm_k24", int'(pwm_b), 0);
      if (k == 32) chk("cold_ach_k32", int'(ach_b), 0);
      if (k == 33) chk("cold_ach_k33", int'(ach_b), 1);
      if (step_b) begin
        nst++;
        first_hi = k;
      end
    end
    chk("cold_quiet_first_period", cz, 0);
    chk("cold_step_count", nst, 1);
    chk("cold_step_pos", first_hi, 33);

    // OFF mode clears everything
    mode = 2'b00;
    run_to(60);
    chk("off_pwm", int'(pwm_b), 0);
    chk("off_ach", int'(ach_b), 0);
    chk("off_step", int'(step_b), 0);
    chk("off_level", int'(u_dut_b.r_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
